// File: rtl/microwave_panel_pkg.sv
// Shared constants and types for the microwave front panel.
// State codes, time-entry width and button bit positions.
package microwave_panel_pkg;

  localparam int TIME_W = 4;

  typedef logic [TIME_W-1:0] time_t;
  typedef logic [2:0]        state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_SET   = 3'd1;
  localparam state_t ST_RUN   = 3'd2;
  localparam state_t ST_PAUSE = 3'd3;
  localparam state_t ST_DONE  = 3'd4;

  localparam int BTN_INC   = 0;
  localparam int BTN_DEC   = 1;
  localparam int BTN_START = 2;
  localparam int BTN_STOP  = 3;

endpackage

// File: rtl/microwave_panel_if.sv
// Panel bus: buttons, door, range power status in; tin/r/beep/state out.
// master = panel/range side driving inputs, slave = the controller.
interface microwave_panel_if;
  import microwave_panel_pkg::*;

  logic   btn_inc;
  logic   btn_dec;
  logic   btn_start;
  logic   btn_stop;
  logic   door_open;
  logic   p;
  time_t  tin;
  logic   r;
  logic   beep;
  state_t state;

  modport master (
    output btn_inc, btn_dec, btn_start, btn_stop,
    output door_open, p,
    input  tin, r, beep, state
  );

  modport slave (
    input  btn_inc, btn_dec, btn_start, btn_stop,
    input  door_open, p,
    output tin, r, beep, state
  );

endinterface

// File: rtl/microwave_panel_btn_edge.sv
// Rising-edge detector for N level buttons with registered history.
// Ports: clk, rst (sync, high), btn[N] levels, rise[N] one-cycle edges.
module microwave_panel_btn_edge #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] btn,
  output logic [N-1:0] rise
);

  logic [N-1:0] prev;

  always_ff @(posedge clk) begin
    if (rst) prev <= '0;
    else     prev <= btn;
  end

  assign rise = btn & ~prev;

endmodule

// File: rtl/microwave_panel.sv
// Front-panel FSM feeding time entry and run request to the range.
// Ports: clk, rst (sync, high), bus (slave): buttons/door/p in, tin/r/beep/state out.
module microwave_panel
  import microwave_panel_pkg::*;
#(
  parameter int unsigned TMAX     = 15,
  parameter int unsigned BEEP_LEN = 8,
  parameter int unsigned START_TO = 4
) (
  input logic              clk,
  input logic              rst,
  microwave_panel_if.slave bus
);

  localparam int BW = $clog2(BEEP_LEN + 1);
  localparam int TW = $clog2(START_TO + 1);

  localparam time_t          T_ONE   = time_t'(1);
  localparam time_t          T_MAX   = time_t'(TMAX);
  localparam logic [BW-1:0]  B_ONE   = BW'(1);
  localparam logic [BW-1:0]  B_LAST  = BW'(BEEP_LEN - 1);
  localparam logic [TW-1:0]  TO_ONE  = TW'(1);
  localparam logic [TW-1:0]  TO_LAST = TW'(START_TO - 1);

  logic [3:0] btn_v;
  logic [3:0] rise;

  assign btn_v[BTN_INC]   = bus.btn_inc;
  assign btn_v[BTN_DEC]   = bus.btn_dec;
  assign btn_v[BTN_START] = bus.btn_start;
  assign btn_v[BTN_STOP]  = bus.btn_stop;

  microwave_panel_btn_edge #(.N(4)) u_btn_edge (
    .clk  (clk),
    .rst  (rst),
    .btn  (btn_v),
    .rise (rise)
  );

  // Only the highest-priority edge of a cycle is acted on.
  logic do_stop, do_start, do_inc, do_dec, any_edge;

  assign do_stop  = rise[BTN_STOP];
  assign do_start = rise[BTN_START] & ~rise[BTN_STOP];
  assign do_inc   = rise[BTN_INC] & ~rise[BTN_START]
                  & ~rise[BTN_STOP];
  assign do_dec   = rise[BTN_DEC] & ~rise[BTN_INC]
                  & ~rise[BTN_START] & ~rise[BTN_STOP];
  assign any_edge = |rise;

  state_t        state_q, state_d;
  time_t         tin_q, tin_d;
  logic          r_q, beep_q;
  logic          seen_q, seen_d;
  logic [TW-1:0] to_q, to_d;
  logic [BW-1:0] bp_q, bp_d;

  always_comb begin
    state_d = state_q;
    tin_d   = tin_q;
    seen_d  = seen_q;
    to_d    = to_q;
    bp_d    = bp_q;
    case (state_q)
      ST_IDLE: begin
        if (do_inc) begin
          tin_d   = T_ONE;
          state_d = ST_SET;
        end
      end
      ST_SET: begin
        if (do_stop) begin
          tin_d   = '0;
          state_d = ST_IDLE;
        end else if (do_start) begin
          if (!bus.door_open) begin
            state_d = ST_RUN;
            seen_d  = 1'b0;
            to_d    = '0;
          end
        end else if (do_inc) begin
          if (tin_q < T_MAX) tin_d = tin_q + T_ONE;
        end else if (do_dec) begin
          tin_d = tin_q - T_ONE;
          if (tin_q == T_ONE) state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (bus.p) seen_d = 1'b1;
        if (bus.door_open || do_stop) begin
          state_d = ST_PAUSE;
        end else if (seen_q && !bus.p) begin
          state_d = ST_DONE;
          tin_d   = '0;
          bp_d    = '0;
        end else if (!seen_q && !bus.p
                     && to_q == TO_LAST) begin
          // range never raised p: give the entry back
          state_d = ST_SET;
        end else if (to_q < TO_LAST) begin
          to_d = to_q + TO_ONE;
        end
      end
      ST_PAUSE: begin
        if (do_stop) begin
          tin_d   = '0;
          state_d = ST_IDLE;
        end else if (do_start && !bus.door_open) begin
          state_d = ST_RUN;
          seen_d  = 1'b0;
          to_d    = '0;
        end
      end
      ST_DONE: begin
        // any activity just silences the beeper
        if (any_edge || bus.door_open) begin
          state_d = ST_IDLE;
        end else if (bp_q == B_LAST) begin
          state_d = ST_IDLE;
        end else begin
          bp_d = bp_q + B_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        tin_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      tin_q   <= '0;
      r_q     <= 1'b0;
      beep_q  <= 1'b0;
      seen_q  <= 1'b0;
      to_q    <= '0;
      bp_q    <= '0;
    end else begin
      state_q <= state_d;
      tin_q   <= tin_d;
      r_q     <= (state_d == ST_RUN);
      beep_q  <= (state_d == ST_DONE);
      seen_q  <= seen_d;
      to_q    <= to_d;
      bp_q    <= bp_d;
    end
  end

  assign bus.tin   = tin_q;
  assign bus.r     = r_q;
  assign bus.beep  = beep_q;
  assign bus.state = state_q;

endmodule

// File: tb/tb_microwave_panel.sv
// Directed and random checks of microwave_panel against a panel model.
// Ports: none; drives the panel interface and checks every cycle.
module tb_microwave_panel;
  import microwave_panel_pkg::*;

  localparam int TMAX     = 15;
  localparam int BEEP_LEN = 8;
  localparam int START_TO = 4;

  localparam int M_IDLE  = 0;
  localparam int M_SET   = 1;
  localparam int M_RUN   = 2;
  localparam int M_PAUSE = 3;
  localparam int M_DONE  = 4;

  logic       clk  = 1'b0;
  logic       rst  = 1'b1;
  logic [3:0] b    = '0;
  logic       door = 1'b0;
  logic       pin  = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  microwave_panel_if bus ();

  assign bus.btn_inc   = b[0];
  assign bus.btn_dec   = b[1];
  assign bus.btn_start = b[2];
  assign bus.btn_stop  = b[3];
  assign bus.door_open = door;
  assign bus.p         = pin;

  microwave_panel #(
    .TMAX     (TMAX),
    .BEEP_LEN (BEEP_LEN),
    .START_TO (START_TO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int       m_st    = M_IDLE;
  int       m_tin   = 0;
  int       m_run   = 0;
  int       m_bp    = 0;
  bit       m_seen  = 1'b0;
  bit [3:0] m_prev  = '0;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Behaviour of one clock, written from the panel rules.
  task automatic model_step();
    bit [3:0] e;
    int act;
    if (rst) begin
      m_st = M_IDLE; m_tin = 0; m_run = 0; m_bp = 0;
      m_seen = 0; m_prev = '0;
      return;
    end
    e = b & ~m_prev;
    m_prev = b;
    if (e[3])      act = 1;
    else if (e[2]) act = 2;
    else if (e[0]) act = 3;
    else if (e[1]) act = 4;
    else           act = 0;
    case (m_st)
      M_IDLE: if (act == 3) begin m_tin = 1; m_st = M_SET; end
      M_SET: begin
        if (act == 1) begin
          m_tin = 0; m_st = M_IDLE;
        end else if (act == 2 && !door) begin
          m_st = M_RUN; m_seen = 0; m_run = 0;
        end else if (act == 3) begin
          m_tin = (m_tin + 1 > TMAX) ? TMAX : m_tin + 1;
        end else if (act == 4) begin
          m_tin = m_tin - 1;
          if (m_tin == 0) m_st = M_IDLE;
        end
      end
      M_RUN: begin
        m_run++;
        if (pin) m_seen = 1;
        if (door || act == 1) m_st = M_PAUSE;
        else if (m_seen && !pin) begin
          m_st = M_DONE; m_tin = 0; m_bp = 0;
        end else if (!m_seen && m_run >= START_TO)
          m_st = M_SET;
      end
      M_PAUSE: begin
        if (act == 1) begin
          m_tin = 0; m_st = M_IDLE;
        end else if (act == 2 && !door) begin
          m_st = M_RUN; m_seen = 0; m_run = 0;
        end
      end
      default: begin
        m_bp++;
        if (e != 0 || door || m_bp >= BEEP_LEN) m_st = M_IDLE;
      end
    endcase
  endtask

  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
    check("m_state", bus.state, m_st);
    check("m_tin", bus.tin, m_tin);
    check("m_r", bus.r, (m_st == M_RUN) ? 1 : 0);
    check("m_beep", bus.beep, (m_st == M_DONE) ? 1 : 0);
  endtask

  task automatic pulse(input int k);
    b[k] = 1'b1;
    cyc();
    b[k] = 1'b0;
    cyc();
  endtask

  task automatic do_reset();
    b = '0; door = 0; pin = 0; rst = 1;
    cyc();
    rst = 0;
  endtask

  initial begin
    int n;
    // reset state
    rst = 1;
    cyc();
    cyc();
    check("rst_state", bus.state, ST_IDLE);
    check("rst_tin", bus.tin, 0);
    check("rst_r", bus.r, 0);
    check("rst_beep", bus.beep, 0);
    rst = 0;

    // inc x3 then dec
    pulse(0); check("inc1", bus.tin, 1);
    pulse(0); check("inc2", bus.tin, 2);
    pulse(0); check("inc3", bus.tin, 3);
    pulse(1); check("dec1", bus.tin, 2);
    check("set_state", bus.state, ST_SET);
    check("set_r", bus.r, 0);

    // held inc acts once
    do_reset();
    b[0] = 1;
    repeat (10) cyc();
    check("held_inc", bus.tin, 1);
    b[0] = 0;
    cyc();

    // saturation
    repeat (16) pulse(0);
    check("sat_tin", bus.tin, 15);

    // full cook to completion
    do_reset();
    repeat (5) pulse(0);
    check("tin5", bus.tin, 5);
    b[2] = 1;
    cyc();
    check("run_r", bus.r, 1);
    b[2] = 0;
    pin = 1;
    repeat (5) cyc();
    pin = 0;
    cyc();
    check("done_state", bus.state, ST_DONE);
    check("done_r", bus.r, 0);
    check("done_tin", bus.tin, 0);
    check("done_beep", bus.beep, 1);
    n = bus.beep ? 1 : 0;
    for (int k = 0; k < 20 && bus.beep; k++) begin
      cyc();
      if (bus.beep) n++;
    end
    check("beep_len", n, BEEP_LEN);
    check("after_beep", bus.state, ST_IDLE);

    // door pauses, start resumes
    do_reset();
    repeat (5) pulse(0);
    b[2] = 1;
    cyc();
    b[2] = 0;
    pin = 1;
    cyc();
    cyc();
    door = 1;
    cyc();
    check("pause_r", bus.r, 0);
    check("pause_state", bus.state, ST_PAUSE);
    door = 0;
    cyc();
    b[2] = 1;
    cyc();
    check("resume_r", bus.r, 1);
    check("resume_state", bus.state, ST_RUN);
    check("resume_tin", bus.tin, 5);
    b[2] = 0;
    cyc();

    // start timeout with p stuck low
    do_reset();
    repeat (3) pulse(0);
    b[2] = 1;
    cyc();
    b[2] = 0;
    n = bus.r ? 1 : 0;
    for (int k = 0; k < 20 && bus.r; k++) begin
      cyc();
      if (bus.r) n++;
    end
    check("to_r_cycles", n, START_TO);
    check("to_state", bus.state, ST_SET);
    check("to_tin", bus.tin, 3);

    // start and stop together: stop wins
    b = 4'b1100;
    cyc();
    check("ss_state", bus.state, ST_IDLE);
    check("ss_tin", bus.tin, 0);
    b = '0;
    cyc();

    // reset mid-run
    do_reset();
    pulse(0);
    b[2] = 1;
    cyc();
    b[2] = 0;
    pin = 1;
    cyc();
    check("mid_run", bus.state, ST_RUN);
    rst = 1;
    cyc();
    check("mr_tin", bus.tin, 0);
    check("mr_r", bus.r, 0);
    check("mr_beep", bus.beep, 0);
    check("mr_state", bus.state, ST_IDLE);
    rst = 0;
    pin = 0;
    cyc();

    // random traffic against the model
    for (int i = 0; i < 1500; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 2) == 0)  b[0] = ~b[0];
      if ($urandom_range(0, 5) == 0)  b[1] = ~b[1];
      if ($urandom_range(0, 4) == 0)  b[2] = ~b[2];
      if ($urandom_range(0, 13) == 0) b[3] = ~b[3];
      if ($urandom_range(0, 29) == 0) door = ~door;
      if ($urandom_range(0, 4) == 0)  pin = ~pin;
      cyc();
    end
    rst = 0;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
